// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART receive front end
package uart_rx_pkg;

  // IDLE/START/DATA/STOP always exist. PARITY is reachable only when
  // UART_RX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam int                  DATA_W       = 8;
  localparam int                  DROP_CNT_W   = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'd255;

  // Increment that sticks at DROP_CNT_MAX instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] drop_sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == DROP_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with a configurable reset value
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops. Both reset to RST_VAL so an idle-high line does
  // not look like an edge when reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_fifo_wr.sv
// rtl/uart_rx_fifo_wr.sv - UART 8N1/8E1 receiver writing bytes into a FIFO; optional macro UART_RX_PARITY_EN
module uart_rx_fifo_wr
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  full,
  output logic                  wr,
  output logic [DATA_W-1:0]     din,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  overrun,
  input  logic                  ovr_clr,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = {{(CW - 1){1'b0}}, 1'b1};

  logic rx_s;

  state_e                  state_q, state_d;
  logic                    rx_prev_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [2:0]              idx_q, idx_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    wr_q, wr_d;
  logic [DATA_W-1:0]       din_q, din_d;
  logic                    ferr_q, ferr_d;
  logic                    ovr_q, ovr_d;
  logic [DROP_CNT_W-1:0]   drop_q, drop_d;
  logic                    par_bad;
`ifdef UART_RX_PARITY_EN
  logic                    par_q, par_d;
  logic                    perr_q, perr_d;
`endif

  logic start_edge;
  logic start_chk;
  logic bit_end;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  assign start_edge = rx_prev_q & ~rx_s;
  assign start_chk  = (state_q == START) && (cnt_q == HALF_M1);
  assign bit_end    = (state_q != IDLE) && (state_q != START) && (cnt_q == BIT_M1);

`ifdef UART_RX_PARITY_EN
  assign par_bad = ^{data_q, par_q};
`else
  assign par_bad = 1'b0;
`endif

  // State register; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: each non-idle state ends on its own sample point.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start_edge) state_d = START;
      START:  if (start_chk)  state_d = rx_s ? IDLE : DATA;
      DATA: begin
        if (bit_end && (idx_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`else
      PARITY: state_d = IDLE;
`endif
      STOP:   if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and flag next values, decided at each sample point.
  always_comb begin
    cnt_d  = (state_q == IDLE || start_chk || bit_end) ? '0 : cnt_q + CNT_ONE;
    idx_d  = idx_q;
    data_d = data_q;
    wr_d   = 1'b0;
    din_d  = din_q;
    ferr_d = 1'b0;
    ovr_d  = ovr_q;
    drop_d = drop_q;
`ifdef UART_RX_PARITY_EN
    par_d  = par_q;
    perr_d = 1'b0;
`endif
    if (start_chk) idx_d = 3'd0;
    if (bit_end && state_q == DATA) begin
      data_d[idx_q] = rx_s;
      idx_d         = idx_q + 3'd1;
    end
`ifdef UART_RX_PARITY_EN
    if (bit_end && state_q == PARITY) par_d = rx_s;
`endif
    if (bit_end && state_q == STOP) begin
      if (!rx_s) begin
        ferr_d = 1'b1;
      end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
        perr_d = 1'b1;
`endif
      end else if (!full) begin
        wr_d  = 1'b1;
        din_d = data_q;
      end else begin
        // Dropped byte; a simultaneous clear still leaves this drop counted.
        ovr_d  = 1'b1;
        drop_d = ovr_clr ? 8'd1 : drop_sat_inc(drop_q);
      end
    end
    if (ovr_clr && !(bit_end && state_q == STOP && rx_s && !par_bad && full)) begin
      ovr_d  = 1'b0;
      drop_d = '0;
    end
  end

  // Datapath registers, edge-detect history and registered output flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      din_q     <= '0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      drop_q    <= '0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      rx_prev_q <= rx_s;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      din_q     <= din_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      drop_q    <= drop_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign wr        = wr_q;
  assign din       = din_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign drop_cnt  = drop_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_wr.sv
// tb/tb_uart_rx_fifo_wr.sv - scoreboard bench for uart_rx_fifo_wr
module tb_uart_rx_fifo_wr;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       full;
  logic       ovr_clr;
  logic       wr;
  logic [7:0] din;
  logic       busy;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic [7:0] drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int last_wr_cyc = -1;
  logic prev_wr = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx_fifo_wr #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .full       (full),
    .wr         (wr),
    .din        (din),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write is popped against the expected byte queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr) begin
        check("wr_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("din", 32'(din), 32'(exp_q.pop_front()));
        check("wr_while_full", 32'(full), 32'd0);
        check("wr_back_to_back", 32'(prev_wr), 32'd0);
        wr_cnt++;
        last_wr_cyc = cyc;
      end
      if (frame_err)  ferr_cnt++;
      if (parity_err) perr_cnt++;
      prev_wr = wr;
    end else begin
      prev_wr = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop_b);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
`ifdef UART_RX_PARITY_EN
    rx = ^b;
    repeat (CPB) tick();
`endif
    rx = stop_b;
    repeat (CPB) tick();
    rx = 1'b1;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_par(input logic [7:0] b, input logic par_b);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = par_b;
    repeat (CPB) tick();
    rx = 1'b1;
    repeat (CPB) tick();
  endtask
`endif

  initial begin
    int t0;
    int w0;
    int f0;
    rst = 1'b1; rx = 1'b1; full = 1'b0; ovr_clr = 1'b0;
    repeat (3) tick();
    check("rst_wr",        32'(wr),         32'd0);
    check("rst_din",       32'(din),        32'h00);
    check("rst_busy",      32'(busy),       32'd0);
    check("rst_frame_err", 32'(frame_err),  32'd0);
    check("rst_par_err",   32'(parity_err), 32'd0);
    check("rst_overrun",   32'(overrun),    32'd0);
    check("rst_drop_cnt",  32'(drop_cnt),   32'd0);
    rst = 1'b0;
    repeat (4) tick();

    // Basic frame and latency from the pin edge to wr.
    exp_q.push_back(8'hA5);
    t0 = cyc;
    send(8'hA5, 1'b1);
    repeat (4) tick();
    check("a5_wr_cnt",  32'(wr_cnt), 32'd1);
    check("a5_latency", 32'(last_wr_cyc - t0), 32'(LAT));
    check("a5_ferr",    32'(ferr_cnt), 32'd0);

    // Stop bit low: frame error, no write; next frame is clean.
    w0 = wr_cnt;
    send(8'h3C, 1'b0);
    repeat (4) tick();
    check("3c_ferr_cnt", 32'(ferr_cnt), 32'd1);
    check("3c_no_wr",    32'(wr_cnt), 32'(w0));
    exp_q.push_back(8'h11);
    send(8'h11, 1'b1);
    repeat (4) tick();
    check("11_wr_cnt", 32'(wr_cnt), 32'(w0 + 1));

    // Back-to-back frames with no idle gap between them.
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h7E);
    send(8'h81, 1'b1);
    send(8'h7E, 1'b1);
    repeat (4) tick();
    check("b2b_wr_cnt", 32'(wr_cnt), 32'(w0 + 3));

    // FIFO full: three drops, then clear.
    w0 = wr_cnt;
    full = 1'b1;
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    send(8'h03, 1'b1);
    repeat (4) tick();
    check("full_no_wr",  32'(wr_cnt),   32'(w0));
    check("ovr_set",     32'(overrun),  32'd1);
    check("drop_3",      32'(drop_cnt), 32'd3);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0; tick();
    check("ovr_cleared",  32'(overrun),  32'd0);
    check("drop_cleared", 32'(drop_cnt), 32'd0);

    // Saturation of the drop counter.
    for (int i = 0; i < 260; i++) send(8'(i), 1'b1);
    repeat (4) tick();
    check("drop_sat", 32'(drop_cnt), 32'd255);
    check("sat_no_wr", 32'(wr_cnt), 32'(w0));
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    full = 1'b0;
    repeat (4) tick();

    // Two-cycle glitch: false start, back to idle by cycle HALF+1.
    w0 = wr_cnt; f0 = ferr_cnt;
    rx = 1'b0; tick(); tick(); rx = 1'b1;
    tick();
    check("glitch_busy_hi", 32'(busy), 32'd1);
    repeat (HALF) tick();
    check("glitch_busy_lo", 32'(busy), 32'd0);
    repeat (CPB * 11) tick();
    check("glitch_no_wr",   32'(wr_cnt),   32'(w0));
    check("glitch_no_ferr", 32'(ferr_cnt), 32'(f0));

    // Reset in the middle of data bit 4 of 0xFF.
    rx = 1'b0;
    repeat (CPB) tick();
    rx = 1'b1;
    repeat (4 * CPB + HALF) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_busy", 32'(busy),       32'd0);
    check("mid_rst_wr",   32'(wr),         32'd0);
    check("mid_rst_din",  32'(din),        32'h00);
    check("mid_rst_ferr", 32'(frame_err),  32'd0);
    check("mid_rst_ovr",  32'(overrun),    32'd0);
    check("mid_rst_drop", 32'(drop_cnt),   32'd0);
    rst = 1'b0;
    repeat (5 * CPB) tick();
    check("mid_rst_no_wr", 32'(wr_cnt),   32'(w0));
    check("mid_rst_no_fe", 32'(ferr_cnt), 32'(f0));
    exp_q.push_back(8'h5A);
    send(8'h5A, 1'b1);
    repeat (4) tick();
    check("5a_wr_cnt", 32'(wr_cnt), 32'(w0 + 1));

`ifdef UART_RX_PARITY_EN
    w0 = wr_cnt;
    exp_q.push_back(8'h07);
    send_par(8'h07, 1'b1);
    repeat (4) tick();
    check("par_good_wr", 32'(wr_cnt), 32'(w0 + 1));
    send_par(8'h07, 1'b0);
    repeat (4) tick();
    check("par_err_cnt", 32'(perr_cnt), 32'd1);
    check("par_bad_nowr", 32'(wr_cnt), 32'(w0 + 1));
    check("par_drop_cnt", 32'(drop_cnt), 32'd0);
`else
    check("par_err_tied", 32'(perr_cnt), 32'd0);
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo_wr.md
# uart_rx_fifo_wr

Serial receive front end that feeds the 16-entry synchronous byte FIFO. It deserialises an asynchronous 8N1 UART line (8E1 when parity is enabled) and pushes each good byte into the FIFO through its wr/din/full write port. Frames that arrive while the FIFO is full are dropped and counted. Framing and parity errors are flagged.

## Interface
- CLKS_PER_BIT, default 16: clk cycles per UART bit; legal range ≥ 4; HALF = CLKS_PER_BIT/2 (floor).
- clk  in  1  system clock, shared with the FIFO.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial line; idle high.
- full  in  1  FIFO full flag.
- wr  out  1  FIFO write strobe; one-cycle pulse per accepted byte.
- din  out  8  byte to FIFO; valid while wr=1, held until the next wr.
- busy  out  1  high in any state other than IDLE.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- parity_err  out  1  one-cycle pulse: parity mismatch; tied 0 when parity is compiled out.
- overrun  out  1  sticky: a good byte was dropped because full=1.
- ovr_clr  in  1  clears overrun and drop_cnt.
- drop_cnt  out  8  count of dropped bytes; saturates at 255.

## Operation
- rx passes through a 2-flop synchronizer to give rx_s. Both flops reset to 1.
- Bit counter: $clog2(CLKS_PER_BIT) bits. Bit index: 3 bits. Shift register: 8 bits, LSB first.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE: a falling edge on rx_s (previous 1, current 0) moves to START and clears the counter. A line held low does not retrigger.
  - START: at count HALF-1, re-sample rx_s. If 0, go to DATA; if 1 (false start), return to IDLE with no flags.
  - DATA: sample rx_s every CLKS_PER_BIT cycles and shift into bit[idx]. After bit 7, go to PARITY (or STOP).
  - PARITY: sample the bit once. Even parity: the XOR of the 8 data bits and the parity bit must be 0.
  - STOP: sample rx_s once, then return to IDLE.
- Decisions at the stop sample:
  - rx_s=0 → frame_err pulse; no write.
  - Parity bad and rx_s=1 → parity_err pulse; no write.
  - Frame good and full=0 → wr pulse with the byte.
  - Frame good and full=1 → no write; overrun←1; drop_cnt←min(drop_cnt+1,255).
- Frame error and parity error together: only frame_err pulses.
- ovr_clr and a new drop in the same cycle: the drop wins, giving overrun=1 and drop_cnt=1.
- wr never asserts while full=1, where full is sampled in the stop-sample cycle.
- At most one wr per frame, so wr is never high on consecutive cycles.

## Timing
- Reset values: wr=0, din=0x00, busy=0, frame_err=0, parity_err=0, overrun=0, drop_cnt=0, FSM=IDLE, sync flops=1.
- Reset asserted mid-frame aborts at the next clk edge. The partial byte is discarded and no flags pulse.
- rx pin to rx_s: 2 cycles.
- Cycle 0 is the first cycle rx_s=0 in IDLE. Sample points:
  - Start check: cycle HALF.
  - Data bit i: cycle HALF+(i+1)·CLKS_PER_BIT.
  - Parity: cycle HALF+9·CLKS_PER_BIT.
  - Stop: cycle HALF+9·CLKS_PER_BIT (no parity) or HALF+10·CLKS_PER_BIT (parity).
- wr, frame_err and parity_err are registered and high in the cycle after the stop sample. din updates in that same cycle.
- The FSM is in IDLE the cycle after the stop sample. A start edge arriving at that point is accepted, giving back-to-back frames with no gap required.

## Configuration
- UART_RX_PARITY_EN defined:
  - PARITY state present; frame is 11 bits (start, 8 data, even parity, stop).
  - parity_err is driven.
- UART_RX_PARITY_EN undefined:
  - PARITY state and parity logic removed; frame is 10 bits.
  - parity_err is tied to 0.
- Port list is identical in both builds.

## Structure
- Package uart_rx_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - DATA_W=8, DROP_CNT_W=8, DROP_CNT_MAX=255.
- Sub-module sync_2ff: 2-flop synchronizer with a reset-value parameter (1 here).
- Top level contains the FSM, counters, shift register, flags and the drop counter.

## Test plan
- CLKS_PER_BIT=16, parity off, FIFO not full, send 0xA5 → one wr pulse with din=0xA5, 2+8+144+1 = 155 cycles after the rx falling edge; frame_err=0.
- 0x3C sent with the stop bit forced to 0 → frame_err pulses once; no wr; the next frame 0x11 is received normally.
- full=1 for 3 consecutive frames, then ovr_clr pulse → no wr, overrun=1, drop_cnt=3; after the clear, overrun=0 and drop_cnt=0. Repeat with 260 drops → drop_cnt=255.
- 2-cycle low glitch on rx → false start, no wr, busy returns to 0 by cycle HALF+1.
- rst asserted at data bit 4 of 0xFF → all outputs at reset values on the next cycle. The following frame 0x5A is written correctly.
- UART_RX_PARITY_EN defined:
  - 0x07 with parity bit 1 → wr with din=0x07.
  - Same byte with parity bit 0 → parity_err pulse, no wr, drop_cnt unchanged.
